// File: rtl/axi_irom_slave_pkg.sv
// Shared AXI read-channel constants: burst encodings, response codes and
// channel widths used by the instruction ROM responder and its storage bank.
package axi_irom_slave_pkg;

  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = 2'b11;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  // Only 32-bit beats are served.
  localparam logic [AXI_SIZE_W-1:0] SIZE_WORD = 3'b010;

  // WRAP bursts must be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_irom_slave_bank.sv
// Single-port synchronous read-first word RAM with a backdoor write port.
// The output register only updates when the read is enabled, so it holds
// the last beat while the R channel is stalled.
module irom_bank
  import axi_irom_slave_pkg::*;
#(
  parameter int MEM_WORDS = 16384
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  output logic [AXI_DATA_W-1:0]        q,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [AXI_DATA_W-1:0]        bd_wdata
);

  logic [AXI_DATA_W-1:0] mem [MEM_WORDS];

  // Backdoor preload/patch of the array contents; storage itself is not reset.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_wdata;
    end
  end

  // Read-first output register: a write to the same word this cycle is seen on the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_irom_slave.sv
// AXI4 read-only instruction memory responder. Accepts one AR burst at a
// time (FIXED/INCR/WRAP), streams the beats from irom_bank and flags
// unsupported requests (SLVERR) and out-of-window beats (DECERR).
module axi_irom_slave
  import axi_irom_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_WORDS  = 16384,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1FC0_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          arid,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [AXI_LEN_W-1:0]         arlen,
  input  logic [AXI_SIZE_W-1:0]        arsize,
  input  logic [AXI_BURST_W-1:0]       arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [AXI_DATA_W-1:0]        rdata,
  output logic [AXI_RESP_W-1:0]        rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [AXI_DATA_W-1:0]        bd_wdata
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] SPAN_WORDS = ADDR_WIDTH'(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA} state_t;

  state_t                   state;
  logic [AXI_LEN_W-1:0]     len_q;
  logic [AXI_LEN_W-1:0]     cnt_q;
  logic [AXI_BURST_W-1:0]   burst_q;
  logic [WORD_W-1:0]        word_q;
  logic                     err_q;

  logic                     ar_err;
  logic [WORD_W-1:0]        word_next;
  logic [WORD_W-1:0]        rd_word;
  logic                     bank_en;
  logic [IDX_W-1:0]         bank_addr;
  logic [AXI_DATA_W-1:0]    bank_q;
  logic                     unused_addr_lsb;

  // Word index of the beat after w; wraps modulo the word-address space.
  function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0]      w,
                                                  input logic [AXI_BURST_W-1:0] bt,
                                                  input logic [3:0]             wrap_mask);
    logic [WORD_W-1:0] mask;
    mask = WORD_W'(wrap_mask);
    case (bt)
      BURST_FIXED: next_word = w;
      BURST_WRAP:  next_word = (w & ~mask) | ((w + WORD_W'(1)) & mask);
      default:     next_word = w + WORD_W'(1);
    endcase
  endfunction

  // Word offset of w from the base of the memory window.
  function automatic logic [ADDR_WIDTH-1:0] word_offset(input logic [WORD_W-1:0] w);
    return ({w, 2'b00} - BASE_ADDR) >> 2;
  endfunction

  // Response for one beat: request-level errors dominate, then the window check.
  function automatic logic [AXI_RESP_W-1:0] beat_resp(input logic              e,
                                                      input logic [WORD_W-1:0] w);
    if (e) begin
      return RESP_SLVERR;
    end
    if (({w, 2'b00} < BASE_ADDR) || (word_offset(w) >= SPAN_WORDS)) begin
      return RESP_DECERR;
    end
    return RESP_OKAY;
  endfunction

  assign ar_err = (arsize != SIZE_WORD) || (arburst == BURST_RSVD) ||
                  ((arburst == BURST_WRAP) && !wrap_len_ok(arlen));

  // Byte lanes within the start word are irrelevant for 32-bit beats.
  assign unused_addr_lsb = ^araddr[1:0];

  assign word_next = next_word(word_q, burst_q, len_q[3:0]);

  // The bank fetches beat 0 in ISSUE and the following beat on each accepted non-final beat.
  assign bank_en   = (state == S_ISSUE) || ((state == S_DATA) && rready && !rlast);
  assign rd_word   = (state == S_ISSUE) ? word_q : word_next;
  assign bank_addr = IDX_W'(word_offset(rd_word));

  // Error beats carry zero data; rresp is registered alongside the bank output.
  assign rdata = (rresp == RESP_OKAY) ? bank_q : '0;

  irom_bank #(
    .MEM_WORDS (MEM_WORDS)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .en       (bank_en),
    .addr     (bank_addr),
    .q        (bank_q),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata)
  );

  // Burst FSM: accept AR, issue the first bank read, then stream beats until rlast is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= BURST_FIXED;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            len_q   <= arlen;
            burst_q <= arburst;
            word_q  <= araddr[ADDR_WIDTH-1:2];
            err_q   <= ar_err;
            cnt_q   <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rvalid <= 1'b1;
          rresp  <= beat_resp(err_q, word_q);
          rlast  <= (len_q == '0);
          state  <= S_DATA;
        end
        S_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              state   <= S_IDLE;
            end else begin
              word_q <= word_next;
              cnt_q  <= cnt_q + 8'd1;
              rresp  <= beat_resp(err_q, word_next);
              rlast  <= ((cnt_q + 8'd1) == len_q);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_irom_slave.md
# axi_irom_slave

AXI4 read-only responder that answers the instruction-side AXI read channel issued by the I-cache refill engine (INCR/WRAP line bursts) and the uncached fetch path (single beats). Backed by a word-addressed synchronous memory preloaded through a backdoor write port. Used as the instruction memory in block-level and core-level simulation and as the boot ROM model on FPGA builds without DDR.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `ID_WIDTH`, 4: AXI ID width.
- `MEM_WORDS`, 16384: memory depth in 32-bit words (64 KiB); power of two.
- `BASE_ADDR`, 32'h1FC0_0000: physical address of word 0.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arid` in ID_WIDTH: read ID.
- `araddr` in ADDR_WIDTH: start byte address.
- `arlen` in 8: beats minus one.
- `arsize` in 3: beat size; only 3'b010 is legal.
- `arburst` in 2: 00 FIXED, 01 INCR, 10 WRAP.
- `arvalid` in 1 / `arready` out 1: AR handshake.
- `rid` out ID_WIDTH: echoes accepted `arid`.
- `rdata` out 32: beat data.
- `rresp` out 2: 00 OKAY, 10 SLVERR, 11 DECERR.
- `rlast` out 1: final beat.
- `rvalid` out 1 / `rready` in 1: R handshake.
- `bd_we` in 1, `bd_addr` in $clog2(MEM_WORDS), `bd_wdata` in 32: backdoor word write.

## Operation
- One outstanding burst; no read interleaving, no write channel.
- FSM: IDLE → ISSUE → DATA → IDLE.
  - IDLE: `arready`=1. On `arvalid&&arready`: latch id, len, burst, start address (bits [1:0] dropped), error flag; beat counter := 0; → ISSUE.
  - ISSUE: one cycle; bank read of beat 0 enabled; → DATA.
  - DATA: `rvalid`=1. On `rvalid&&rready`: if `rlast` → IDLE, else counter+1, address advances, bank read of next beat enabled the same cycle, so next beat is valid next cycle.
- Bank enable = ISSUE || (DATA && rready && !rlast); bank output holds when not enabled, so `rdata` is stable while `rready`=0.
- Address advance (word index w, 30-bit, wraps mod 2^30):
  - FIXED: w unchanged.
  - INCR: w+1.
  - WRAP: w = (w & ~mask) | ((w+1) & mask), mask = arlen[3:0]; arlen must be 1, 3, 7 or 15.
- Errors:
  - arsize≠3'b010, arburst=2'b11, or WRAP with illegal arlen → every beat `rresp`=SLVERR, `rdata`=0; still exactly arlen+1 beats.
  - Otherwise per beat: (byte address − BASE_ADDR)>>2 ≥ MEM_WORDS or address below BASE_ADDR → that beat DECERR, `rdata`=0; other beats OKAY.
- Backdoor write has priority for port arbitration; a read and write to the same word in one cycle returns old data (read-first). Writes allowed in any state.

## Timing
- Reset values: `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=0, `rid`=0, `rdata`=0, state IDLE. `arready` rises the first cycle after `rst` deasserts.
- AR accepted at edge N → first `rvalid` high after edge N+2 (2-cycle latency).
- With `rready` held high: one beat per cycle; 16-beat burst occupies cycles N+2..N+17; `arready` high again after the edge accepting `rlast`; next AR can be accepted that cycle; no AR/R overlap.
- `rvalid` never drops without handshake; `rdata`/`rresp`/`rlast`/`rid` stable while `rvalid&&!rready`.
- `rst` mid-burst: burst abandoned, outputs to reset values next edge, no further beats.
- `rlast` asserted exactly on beat arlen; arlen=0 gives a single beat with `rlast`=1.

## Structure
- Burst-type, response-code and AXI width constants go in the shared cache/AXI defines package; FSM state enum is local.
- Sub-module `irom_bank`: single-port synchronous read-first RAM, `MEM_WORDS`×32, enable, output register reset to 0, backdoor write port.
- Top: FSM, address generator, error decode, R-channel registers.

## Test plan
- Backdoor-write word k = 32'hA500_0000+k; INCR arlen=7 at 0x1FC0_0020, rready=1 → 8 OKAY beats A500_0008..A500_000F, rlast on 8th, first rvalid 2 cycles after AR.
- WRAP arlen=3 at 0x1FC0_0038 → words 0x0E,0x0F,0x0C,0x0D; rlast on 4th.
- Same INCR with rready toggling 1/0 each cycle → identical data sequence, rdata stable on stalled cycles, 15-16 cycle completion.
- arsize=3'b011, arlen=3 → 4 beats SLVERR, rdata 0; INCR arlen=3 starting at last word (0x1FC0_FFFC) → beat0 OKAY, beats1-3 DECERR.
- rst asserted at beat 3 of a 16-beat burst → rvalid 0 next cycle, arready 1 after release, fresh FIXED arlen=0 returns one OKAY beat with rid echoed.
- Backdoor write to word being read in ISSUE → old value returned; re-read returns new value.
